// File: rtl/f1_reaction_timer.sv
`default_nettype none
// =============================================================================
// f1_reaction_timer - F1 start lights with random hold, reaction timing, false start/timeout
// Revision 1.0
// =============================================================================
module f1_reaction_timer #(
  parameter int          NUM_LIGHTS  = 8,
  parameter int          DELAY_WIDTH = 4,
  parameter int          TIME_WIDTH  = 12,
  parameter int          RT_DIV      = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'h0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  button,
  input  logic [15:0]           tick_n,
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  false_start,
  output logic                  timeout,
  output logic [TIME_WIDTH-1:0] reaction_time
);

  localparam int                   PRE_W     = (RT_DIV > 1) ? $clog2(RT_DIV) : 1;
  localparam logic [PRE_W-1:0]     PRE_MAX   = PRE_W'(RT_DIV - 1);
  localparam logic [TIME_WIDTH-1:0] RT_MAX   = '1;
  localparam logic [TIME_WIDTH-1:0] RT_PENULT = ~(TIME_WIDTH'(1));
  localparam logic [NUM_LIGHTS-1:0] ALL_ON   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_HOLD  = 2'd2,
    S_REACT = 2'd3
  } state_t;

  state_t                  state;
  logic                    start_q;
  logic                    button_q;
  logic                    armed;
  logic [15:0]             lfsr;
  logic [15:0]             tick_n_l;
  logic [15:0]             tick_cnt;
  logic [DELAY_WIDTH-1:0]  hold_cnt;
  logic [PRE_W-1:0]        rt_pre;
  logic [TIME_WIDTH-1:0]   rt_cnt;

  logic                    start_e;
  logic                    button_e;
  logic                    tick;
  logic                    pre_wrap;
  logic                    sat_next;
  logic                    lfsr_fb;
  logic [NUM_LIGHTS-1:0]   fill_next;
  logic [DELAY_WIDTH-1:0]  hold_load;

  // armed masks the first cycle after reset so a level held through reset is not an edge
  assign start_e   = start  & ~start_q  & armed;
  assign button_e  = button & ~button_q & armed;

  assign tick      = (tick_cnt == tick_n_l);
  assign pre_wrap  = (rt_pre == PRE_MAX);
  assign sat_next  = pre_wrap && (rt_cnt == RT_PENULT);
  assign lfsr_fb   = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
  assign fill_next = {data_out[NUM_LIGHTS-2:0], 1'b1};
  assign hold_load = (lfsr[DELAY_WIDTH-1:0] == '0) ? DELAY_WIDTH'(1) : lfsr[DELAY_WIDTH-1:0];

  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      start_q       <= 1'b0;
      button_q      <= 1'b0;
      armed         <= 1'b0;
      lfsr          <= LFSR_SEED;
      tick_n_l      <= '0;
      tick_cnt      <= '0;
      hold_cnt      <= '0;
      rt_pre        <= '0;
      rt_cnt        <= '0;
      data_out      <= '0;
      result_valid  <= 1'b0;
      false_start   <= 1'b0;
      timeout       <= 1'b0;
      reaction_time <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      start_q      <= start;
      button_q     <= button;
      armed        <= 1'b1;
      result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_e) begin
            state       <= S_FILL;
            tick_n_l    <= tick_n;
            tick_cnt    <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            data_out    <= '0;
          end
        end

        S_FILL, S_HOLD: begin
          tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
          // a press before lights out wins even against the final hold tick
          if (button_e) begin
            false_start  <= 1'b1;
            data_out     <= '0;
            result_valid <= 1'b1;
            state        <= S_IDLE;
          end else if (tick) begin
            if (state == S_FILL) begin
              data_out <= fill_next;
              if (fill_next == ALL_ON) begin
                state    <= S_HOLD;
                hold_cnt <= hold_load;
              end
            end else if (hold_cnt == DELAY_WIDTH'(1)) begin
              data_out <= '0;
              state    <= S_REACT;
              rt_pre   <= '0;
              rt_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt - DELAY_WIDTH'(1);
            end
          end
        end

        S_REACT: begin
          rt_pre <= pre_wrap ? '0 : rt_pre + PRE_W'(1);
          if (pre_wrap && (rt_cnt != RT_MAX)) begin
            rt_cnt <= rt_cnt + TIME_WIDTH'(1);
          end
          if (button_e) begin
            reaction_time <= rt_cnt;
            result_valid  <= 1'b1;
            state         <= S_IDLE;
          end else if (sat_next) begin
            reaction_time <= RT_MAX;
            timeout       <= 1'b1;
            result_valid  <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// =============================================================================
// tb_f1_reaction_timer - directed and randomized runs against a schedule-based model
// Revision 1.0
// =============================================================================
module tb_f1_reaction_timer;

  localparam int          NL   = 8;
  localparam int          DW   = 4;
  localparam int          TW   = 4;
  localparam int          RTD  = 2;
  localparam logic [15:0] SEED = 16'h0001;
  // last REACT cycle index; the counter reaches all ones at the end of it
  localparam int          KSAT = ((1 << TW) - 1) * RTD - 1;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          start  = 1'b0;
  logic          button = 1'b0;
  logic [15:0]   tick_n = 16'd0;
  logic [NL-1:0] data_out;
  logic          busy;
  logic          result_valid;
  logic          false_start;
  logic          timeout;
  logic [TW-1:0] reaction_time;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [15:0]   lfsr_m = SEED;
  int            prev_rt = 0;

  always #5 clk = ~clk;

  f1_reaction_timer #(
    .NUM_LIGHTS (NL),
    .DELAY_WIDTH(DW),
    .TIME_WIDTH (TW),
    .RT_DIV     (RTD),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .button       (button),
    .tick_n       (tick_n),
    .data_out     (data_out),
    .busy         (busy),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .reaction_time(reaction_time)
  );

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    return v;
  endfunction

  // lamp pattern t edges after the start edge
  function automatic logic [63:0] lamps(input int t, input int per, input int fe, input int re);
    if (t < fe)      return (64'd1 << (t / per)) - 64'd1;
    else if (t < re) return (64'd1 << NL) - 64'd1;
    else             return 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) lfsr_m = lfsr_adv(lfsr_m, 1);
    @(negedge clk);
  endtask

  // idle until a run started at the next edge would load the requested hold value
  task automatic wait_nibble(input int tn, input int val);
    int          n;
    logic [15:0] lf;
    n  = 0;
    lf = lfsr_adv(lfsr_m, NL * (tn + 1));
    while ((lf[DW-1:0] != DW'(val)) && (n < 2000)) begin
      step();
      n++;
      lf = lfsr_adv(lfsr_m, NL * (tn + 1));
    end
    chk("nibble_search", 64'(n < 2000), 64'd1);
  endtask

  // mode 0: press in REACT cycle p; 1: false start at edge p; 2: timeout; 3: press on lights-out edge
  task automatic do_run(input int tn, input int mode, input int p);
    int          per, fe, re, d, endt, exp_rt;
    logic [15:0] lf;
    per = tn + 1;
    fe  = NL * per;
    lf  = lfsr_adv(lfsr_m, fe);
    d   = int'(lf[DW-1:0]);
    if (d == 0) d = 1;
    re  = fe + d * per;
    case (mode)
      0:       endt = re + p + 1;
      1:       endt = 1 + ((p - 1) % re);
      3:       endt = re;
      default: endt = re + KSAT + 1;
    endcase

    tick_n = 16'(tn);
    start  = 1'b1;
    button = 1'b0;
    step();
    chk("start_busy",  64'(busy), 64'd1);
    chk("start_lamps", 64'(data_out), 64'd0);
    chk("start_fs",    64'(false_start), 64'd0);
    chk("start_to",    64'(timeout), 64'd0);
    chk("start_rt",    64'(reaction_time), 64'(prev_rt));

    for (int t = 1; t <= endt; t++) begin
      start  = (t == 3);
      button = (mode != 2) && (t == endt);
      step();
      if (t < endt) begin
        chk("run_lamps", 64'(data_out), lamps(t, per, fe, re));
        chk("run_busy",  64'(busy), 64'd1);
        chk("run_rv",    64'(result_valid), 64'd0);
      end
    end

    exp_rt = (mode == 0) ? p / RTD : (mode == 2) ? (1 << TW) - 1 : prev_rt;
    chk("end_rv",    64'(result_valid), 64'd1);
    chk("end_busy",  64'(busy), 64'd0);
    chk("end_lamps", 64'(data_out), 64'd0);
    chk("end_fs",    64'(false_start), 64'(mode == 1 || mode == 3));
    chk("end_to",    64'(timeout), 64'(mode == 2));
    chk("end_rt",    64'(reaction_time), 64'(exp_rt));

    start = 1'b0;
    step();
    chk("post_rv",   64'(result_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_fs",   64'(false_start), 64'(mode == 1 || mode == 3));
    chk("post_rt",   64'(reaction_time), 64'(exp_rt));
    button = 1'b0;
    step();
    prev_rt = exp_rt;
  endtask

  initial begin
    // reset held with start high, then released while start stays high
    rst    = 1'b0;
    start  = 1'b1;
    tick_n = 16'd3;
    step();
    step();
    chk("rst_lamps", 64'(data_out), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_rv",    64'(result_valid), 64'd0);
    chk("rst_fs",    64'(false_start), 64'd0);
    chk("rst_to",    64'(timeout), 64'd0);
    chk("rst_rt",    64'(reaction_time), 64'd0);
    rst = 1'b1;
    step();
    step();
    step();
    chk("norun_busy",  64'(busy), 64'd0);
    chk("norun_lamps", 64'(data_out), 64'd0);
    start = 1'b0;
    step();

    do_run(3, 0, 10);          // reaction_time 5
    wait_nibble(3, 0);
    do_run(3, 0, 0);           // shortest hold, press on first REACT cycle
    wait_nibble(3, 5);
    do_run(3, 1, 13);          // false start while 07 lit
    do_run(2, 3, 0);           // press together with the final hold tick
    do_run(1, 2, 0);           // timeout
    do_run(1, 0, KSAT);        // press together with saturation
    do_run(0, 0, 1);

    for (int i = 0; i < 12; i++) begin
      int tn, mode, p;
      tn   = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      p    = (mode == 0) ? int'($urandom_range(0, KSAT)) : int'($urandom_range(1, 300));
      do_run(tn, mode, p);
    end

    // asynchronous reset in HOLD
    tick_n = 16'd1;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NL * 2 + 1; i++) step();
    chk("hold_lamps", 64'(data_out), (64'd1 << NL) - 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_lamps", 64'(data_out), 64'd0);
    chk("arst_busy",  64'(busy), 64'd0);
    chk("arst_rv",    64'(result_valid), 64'd0);
    chk("arst_rt",    64'(reaction_time), 64'd0);
    lfsr_m  = SEED;
    prev_rt = 0;
    step();
    chk("arst_rv2", 64'(result_valid), 64'd0);
    rst = 1'b1;
    step();
    step();
    chk("rel_rv",   64'(result_valid), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    do_run(0, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
Parametrised successor to the F1 start-lights sequencer. Fills NUM_LIGHTS lamps one per tick, holds them all lit for a pseudo-random number of ticks, then extinguishes them and measures the player's reaction time. Detects false starts and timeouts. Self-contained: internal tick prescaler, free-running LFSR and control FSM; drives the LED bar and result display directly.

Parameters:
NUM_LIGHTS, 8, number of lamps in data_out (2..32)
DELAY_WIDTH, 4, LFSR bits used for the hold delay in ticks (1..8)
TIME_WIDTH, 12, width of the reaction_time counter
RT_DIV, 1000, clock cycles per reaction-time unit (>=1)
LFSR_SEED, 16'h0001, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset; 0 clears all state immediately
start  in  1  level input; rising edge begins a run
button  in  1  level input; rising edge is the player's response
tick_n  in  16  light-step period minus one, in cycles; sampled on run start
data_out  out  NUM_LIGHTS  lamp drive, bit 0 lights first
busy  out  1  high in FILL, HOLD, REACT
result_valid  out  1  one-cycle pulse when a run ends (any outcome)
false_start  out  1  sticky: run ended by button before lights out
timeout  out  1  sticky: reaction counter saturated without a press
reaction_time  out  TIME_WIDTH  last measured time, RT_DIV-cycle units

Behaviour:
- Reset (rst=0): all outputs 0, FSM IDLE, LFSR=LFSR_SEED, edge registers 0.
- Edge detect: start_e = start & ~start_q, button_e = button & ~button_q; *_q registered each cycle. Holding an input high yields one event.
- LFSR: 16-bit Fibonacci, taps 16,15,13,4, advances every cycle in every state.
- Tick: prescaler runs in FILL and HOLD only; tick every tick_n_latched+1 cycles; cleared on entry to FILL.
- IDLE: start_e -> FILL; latch tick_n; clear false_start, timeout, data_out. reaction_time retained until then. button_e ignored.
- FILL: each tick, data_out <= {data_out[N-2:0],1}. On the tick that makes data_out all ones -> HOLD; load hold counter with LFSR[DELAY_WIDTH-1:0], value 0 forced to 1. Ticks never clear the hold counter.
- HOLD: each tick decrements hold counter; the tick taking it to 0 sets data_out=0 and enters REACT. Reaction counter and its prescaler cleared on entry.
- REACT: prescaler counts 0..RT_DIV-1; on wrap, reaction counter increments, saturating at all-ones. Press in cycle k after entry (entry cycle k=0) gives reaction_time = floor(k/RT_DIV).
- button_e in REACT -> latch reaction counter into reaction_time, pulse result_valid, -> IDLE.
- Saturation reached with no press -> reaction_time=all ones, timeout=1, pulse result_valid, -> IDLE.
- button_e in FILL or HOLD -> false_start=1, data_out=0, result_valid pulse, reaction_time unchanged, -> IDLE.
- Simultaneous: button_e on the same cycle as the final HOLD tick counts as false start. button_e and saturation together counts as a press (timeout=0). start_e outside IDLE is ignored.
- busy is a combinational decode of state. All other outputs are registered.
- rst low mid-run: immediate return to reset values; no result_valid pulse.

Test Plan:
- Reset: rst=0 with start=1 held -> data_out=0, busy=0, reaction_time=0, all flags 0. Release rst while start still high -> no run (no rising edge).
- Fill timing: NUM_LIGHTS=8, tick_n=3, start pulse -> data_out=01,03,07,...,FF at 4, 8, ..., 32 cycles after the edge. busy=1 from the cycle after the edge.
- Hold: force LFSR low nibble=0 at HOLD entry -> lights out exactly 1 tick (4 cycles) after FF. Nibble=5 -> 20 cycles.
- Reaction: RT_DIV=2, button rises 10 cycles after REACT entry -> reaction_time=5, result_valid single pulse, busy=0 next cycle.
- False start: button rises while data_out=07 -> false_start=1, data_out=00, result_valid pulse, reaction_time unchanged. Next start_e clears false_start.
- Timeout and reset: TIME_WIDTH=4, RT_DIV=1, no press -> reaction_time=15, timeout=1 after 15 REACT cycles. Separate run: rst=0 in HOLD -> outputs zero asynchronously, no pulse.
